// File: rtl/overture_io_bridge.sv
// overture_io_bridge: input/output FIFO stage around overture_cpu.
// Gates the CPU run line so reads and writes never lose data.
module overture_io_bridge #(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  localparam int ICW = $clog2(IN_DEPTH + 1),
  localparam int OCW = $clog2(OUT_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run_req,
  input  logic [7:0]     cpu_instr,
  input  logic [7:0]     cpu_out_port,
  output logic           cpu_run,
  output logic [7:0]     cpu_in_port,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [7:0]     out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [ICW-1:0] in_count,
  output logic [OCW-1:0] out_count,
  output logic [15:0]    stall_cycles
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  logic [7:0]     in_mem [IN_DEPTH];
  logic [7:0]     out_mem [OUT_DEPTH];
  logic [IAW-1:0] in_rd, in_wr;
  logic [OAW-1:0] out_rd, out_wr;
  logic           cap_pend;
  logic           is_rd, is_wr, stall;
  logic           in_push, in_pop, out_push, out_pop;
  logic [OCW:0]   out_fill;

  // Decode I/O moves and decide whether the CPU may advance
  always_comb begin
    is_rd    = (cpu_instr[7:6] == 2'b10) && (cpu_instr[5:3] == 3'b110);
    is_wr    = (cpu_instr[7:6] == 2'b10) && (cpu_instr[2:0] == 3'b110);
    out_fill = {1'b0, out_count} + (OCW+1)'(cap_pend);
    stall    = (is_rd && in_count == '0) ||
               (is_wr && out_fill >= (OCW+1)'(OUT_DEPTH));
    cpu_run  = run_req && !stall && !reset;
    in_ready = in_count < ICW'(IN_DEPTH);
    out_valid = out_count != '0;
    in_push  = in_valid && in_ready;
    in_pop   = cpu_run && is_rd && in_count != '0;
    out_push = cap_pend && out_count < OCW'(OUT_DEPTH);
    out_pop  = out_valid && out_ready;
    cpu_in_port = (in_count == '0) ? 8'h00 : in_mem[in_rd];
    out_data    = out_valid ? out_mem[out_rd] : 8'h00;
  end

  // Input FIFO: host pushes, CPU reads pop
  always_ff @(posedge clk) begin
    if (reset) begin
      in_rd    <= '0;
      in_wr    <= '0;
      in_count <= '0;
    end else begin
      if (in_push) begin
        in_mem[in_wr] <= in_data;
        in_wr <= in_wr + 1'b1;
      end
      if (in_pop)
        in_rd <= in_rd + 1'b1;
      if (in_push && !in_pop)
        in_count <= in_count + 1'b1;
      else if (!in_push && in_pop)
        in_count <= in_count - 1'b1;
    end
  end

  // Output FIFO: capture the port one cycle after a write executes
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_pend  <= 1'b0;
      out_rd    <= '0;
      out_wr    <= '0;
      out_count <= '0;
    end else begin
      cap_pend <= cpu_run && is_wr;
      if (out_push) begin
        out_mem[out_wr] <= cpu_out_port;
        out_wr <= out_wr + 1'b1;
      end
      if (out_pop)
        out_rd <= out_rd + 1'b1;
      if (out_push && !out_pop)
        out_count <= out_count + 1'b1;
      else if (!out_push && out_pop)
        out_count <= out_count - 1'b1;
    end
  end

  // Saturating count of cycles the host wanted to run but was held
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (run_req && !cpu_run && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
endmodule

// File: tb/tb_overture_io_bridge.sv
// tb_overture_io_bridge: scoreboard bench for overture_io_bridge.
// The bench plays the CPU: it drives cpu_instr and updates cpu_out_port.
module tb_overture_io_bridge;
  localparam logic [7:0] RD  = 8'hB1;
  localparam logic [7:0] WR  = 8'h9E;
  localparam logic [7:0] NOP = 8'h00;

  logic clk = 0;
  always #5 clk = ~clk;

  logic reset, run_req, in_valid, out_ready;
  logic [7:0] cpu_instr, cpu_out_port, in_data;
  logic cpu_run, in_ready, out_valid;
  logic [7:0] cpu_in_port, out_data;
  logic [4:0] in_count, out_count;
  logic [15:0] stall_cycles;

  logic b_run_req, b_out_ready;
  logic [7:0] b_cpu_instr, b_cpu_out_port;
  logic b_cpu_run, b_in_ready, b_out_valid;
  logic [7:0] b_cpu_in_port, b_out_data;
  logic [1:0] b_in_count, b_out_count;
  logic [15:0] b_stall_cycles;

  overture_io_bridge dut (
    .clk(clk), .reset(reset), .run_req(run_req),
    .cpu_instr(cpu_instr), .cpu_out_port(cpu_out_port),
    .cpu_run(cpu_run), .cpu_in_port(cpu_in_port),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_count(in_count), .out_count(out_count),
    .stall_cycles(stall_cycles)
  );

  overture_io_bridge #(.IN_DEPTH(2), .OUT_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .run_req(b_run_req),
    .cpu_instr(b_cpu_instr), .cpu_out_port(b_cpu_out_port),
    .cpu_run(b_cpu_run), .cpu_in_port(b_cpu_in_port),
    .in_data(8'h00), .in_valid(1'b0), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .in_count(b_in_count), .out_count(b_out_count),
    .stall_cycles(b_stall_cycles)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  logic [7:0] b_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [7:0] b);
    in_data = b;
    in_valid = 1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_ready got %b want 1", in_ready);
    end
    in_q.push_back(b);
    cyc();
    in_valid = 0;
  endtask

  task automatic exec(input logic [7:0] ins, input logic [7:0] wv);
    logic [7:0] exp;
    bit done;
    done = 0;
    cpu_instr = ins;
    run_req = 1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (cpu_run === 1'b1) begin
        if (ins == RD) begin
          exp = (in_q.size() > 0) ? in_q.pop_front() : 8'hxx;
          n_chk++;
          if (cpu_in_port !== exp) begin
            n_fail++;
            $display("FAIL cpu_read got %h want %h", cpu_in_port, exp);
          end
        end
        if (ins == WR) out_q.push_back(wv);
        cyc();
        if (ins == WR) cpu_out_port = wv;
        done = 1;
      end else begin
        cyc();
      end
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL exec_timeout instr %h got stalled want run", ins);
    end
    cpu_instr = NOP;
  endtask

  task automatic pop_out();
    logic [7:0] exp;
    exp = (out_q.size() > 0) ? out_q.pop_front() : 8'hxx;
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      n_fail++;
      $display("FAIL out_pop got v=%b d=%h want v=1 d=%h",
               out_valid, out_data, exp);
    end
    out_ready = 1;
    cyc();
    out_ready = 0;
  endtask

  task automatic b_pop();
    logic [7:0] exp;
    exp = (b_q.size() > 0) ? b_q.pop_front() : 8'hxx;
    n_chk++;
    if (b_out_valid !== 1'b1 || b_out_data !== exp) begin
      n_fail++;
      $display("FAIL b_pop got v=%b d=%h want v=1 d=%h",
               b_out_valid, b_out_data, exp);
    end
    b_out_ready = 1;
    cyc();
    b_out_ready = 0;
  endtask

  task automatic b_run_chk(input logic exp, input string nm);
    #1;
    n_chk++;
    if (b_cpu_run !== exp) begin
      n_fail++;
      $display("FAIL %s got run=%b want %b", nm, b_cpu_run, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    run_req = 1;
    b_run_req = 0;
    cpu_instr = NOP;
    b_cpu_instr = NOP;
    cpu_out_port = 0;
    b_cpu_out_port = 0;
    in_data = 0;
    in_valid = 0;
    out_ready = 0;
    b_out_ready = 0;
    cyc();
    cyc();
    n_chk++;
    if ({in_ready, out_valid, out_data, cpu_in_port, cpu_run,
         in_count, out_count, stall_cycles} !== {1'b1, 1'b0, 8'h00,
         8'h00, 1'b0, 5'd0, 5'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b ov=%b od=%h ip=%h run=%b ic=%0d oc=%0d sc=%0d want 1 0 00 00 0 0 0 0",
               in_ready, out_valid, out_data, cpu_in_port, cpu_run,
               in_count, out_count, stall_cycles);
    end
    reset = 0;
    run_req = 0;
    cyc();
  endtask

  task automatic test_input_reads();
    push_in(8'h05);
    push_in(8'h0A);
    n_chk++;
    if (in_count !== 5'd2 || cpu_in_port !== 8'h05) begin
      n_fail++;
      $display("FAIL in_fill got cnt=%0d head=%h want 2 05",
               in_count, cpu_in_port);
    end
    exec(RD, 0);
    exec(RD, 0);
    n_chk++;
    if (in_count !== 5'd0) begin
      n_fail++;
      $display("FAIL in_drain got %0d want 0", in_count);
    end
  endtask

  task automatic test_read_stall();
    logic [15:0] s0;
    cpu_instr = RD;
    run_req = 1;
    #1;
    s0 = stall_cycles;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (cpu_run !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_stall got run=%b want 0", cpu_run);
      end
      cyc();
    end
    n_chk++;
    if (stall_cycles !== s0 + 16'd3) begin
      n_fail++;
      $display("FAIL stall_cnt got %0d want %0d", stall_cycles, s0 + 3);
    end
    in_data = 8'h33;
    in_valid = 1;
    in_q.push_back(8'h33);
    #1;
    n_chk++;
    if (cpu_run !== 1'b0) begin
      n_fail++;
      $display("FAIL push_cycle_run got %b want 0", cpu_run);
    end
    cyc();
    in_valid = 0;
    exec(RD, 0);
    n_chk++;
    if (stall_cycles !== s0 + 16'd4 || in_count !== 5'd0) begin
      n_fail++;
      $display("FAIL resume got sc=%0d ic=%0d want %0d 0",
               stall_cycles, in_count, s0 + 4);
    end
    run_req = 0;
  endtask

  task automatic test_back_to_back();
    exec(WR, 8'h07);
    exec(WR, 8'h07);
    exec(WR, 8'h07);
    cyc();
    cyc();
    n_chk++;
    if (out_count !== 5'd3) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 3", out_count);
    end
    for (int i = 0; i < 3; i++) pop_out();
    run_req = 0;
  endtask

  task automatic test_out_full();
    b_run_req = 1;
    b_cpu_instr = WR;
    b_run_chk(1, "full_w1");
    b_q.push_back(8'h11);
    cyc();
    b_cpu_out_port = 8'h11;
    b_run_chk(1, "full_w2");
    b_q.push_back(8'h22);
    cyc();
    b_cpu_out_port = 8'h22;
    b_run_chk(0, "full_w3a");
    cyc();
    b_run_chk(0, "full_w3b");
    n_chk++;
    if (b_out_count !== 2'd2) begin
      n_fail++;
      $display("FAIL full_count got %0d want 2", b_out_count);
    end
    b_pop();
    b_run_chk(1, "full_w3go");
    b_q.push_back(8'h33);
    cyc();
    b_cpu_out_port = 8'h33;
    b_run_chk(0, "full_w4a");
    cyc();
    b_run_chk(0, "full_w4b");
    b_pop();
    b_run_chk(1, "full_w4go");
    b_q.push_back(8'h44);
    cyc();
    b_cpu_out_port = 8'h44;
    b_cpu_instr = NOP;
    cyc();
    b_pop();
    b_pop();
    n_chk++;
    if (b_out_count !== 2'd0) begin
      n_fail++;
      $display("FAIL full_drain got %0d want 0", b_out_count);
    end
    b_run_req = 0;
  endtask

  task automatic test_push_pop_same();
    push_in(8'hAA);
    in_data = 8'hBB;
    in_valid = 1;
    cpu_instr = RD;
    run_req = 1;
    #1;
    n_chk++;
    if (cpu_run !== 1'b1 || cpu_in_port !== 8'hAA) begin
      n_fail++;
      $display("FAIL same_pre got run=%b head=%h want 1 aa",
               cpu_run, cpu_in_port);
    end
    void'(in_q.pop_front());
    in_q.push_back(8'hBB);
    cyc();
    in_valid = 0;
    cpu_instr = NOP;
    n_chk++;
    if (in_count !== 5'd1 || cpu_in_port !== 8'hBB) begin
      n_fail++;
      $display("FAIL same_post got cnt=%0d head=%h want 1 bb",
               in_count, cpu_in_port);
    end
    run_req = 0;
  endtask

  task automatic test_mid_reset();
    push_in(8'h42);
    exec(WR, 8'h5A);
    cpu_instr = WR;
    run_req = 1;
    #1;
    n_chk++;
    if (cpu_run !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wr got run=%b want 1", cpu_run);
    end
    cyc();
    cpu_instr = NOP;
    cpu_out_port = 8'h6B;
    reset = 1;
    cyc();
    reset = 0;
    in_q.delete();
    out_q.delete();
    #1;
    n_chk++;
    if (in_count !== 0 || out_count !== 0 || out_valid !== 0 ||
        stall_cycles !== 0 || cpu_in_port !== 0) begin
      n_fail++;
      $display("FAIL mid_reset got ic=%0d oc=%0d ov=%b sc=%0d ip=%h want 0 0 0 0 00",
               in_count, out_count, out_valid, stall_cycles, cpu_in_port);
    end
    cyc();
    cyc();
    n_chk++;
    if (out_count !== 0 || stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL no_capture got oc=%0d sc=%0d want 0 0",
               out_count, stall_cycles);
    end
    run_req = 0;
  endtask

  initial begin
    test_reset();
    test_input_reads();
    test_read_stall();
    test_back_to_back();
    test_out_full();
    test_push_pop_same();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
